// File: rtl/reg_file_param.sv
// reg_file_param: NUM_REGS x WIDTH counter-capable register file with zero/sticky-overflow flags and two async read ports
module reg_file_param #(
  parameter int WIDTH = 8,
  parameter int NUM_REGS = 4,
  parameter int SATURATE = 0,
  parameter int BYPASS = 0,
  localparam int SELW = $clog2(NUM_REGS)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [1:0]          FunSel,
  input  logic [NUM_REGS-1:0] RegSel,
  input  logic [WIDTH-1:0]    I,
  input  logic [SELW-1:0]     OutASel,
  input  logic [SELW-1:0]     OutBSel,
  output logic [WIDTH-1:0]    OutA,
  output logic [WIDTH-1:0]    OutB,
  output logic [NUM_REGS-1:0] ZeroFlag,
  output logic [NUM_REGS-1:0] OvfFlag
);
  localparam int P = 2 ** SELW;
  logic [WIDTH-1:0] regs [P];
  logic [P-1:0] byp_hit;
  genvar k;
  for (k = 0; k < P; k++) begin : g_reg
    if (k < NUM_REGS) begin : g_live
      logic [WIDTH-1:0] q, nxt;
      logic o, wrap;
      always_comb begin
        wrap = FunSel == 2'd0 ? q == '0 : FunSel == 2'd1 ? &q : 1'b0;
        nxt = FunSel == 2'd2 ? I :
              FunSel == 2'd3 ? '0 :
              (wrap && SATURATE != 0) ? q :
              FunSel == 2'd1 ? q + 1'b1 : q - 1'b1;
      end
      always_ff @(posedge CLK)
        if (RST) begin
          q <= '0;
          o <= 1'b0;
        end else if (!RegSel[k]) begin
          q <= nxt;
          o <= FunSel == 2'd3 ? 1'b0 : o | wrap;
        end
      assign regs[k] = q;
      assign ZeroFlag[k] = q == '0;
      assign OvfFlag[k] = o;
      assign byp_hit[k] = BYPASS != 0 && !RST && !RegSel[k] && FunSel == 2'd2;
    end else begin : g_pad
      // indices past NUM_REGS read as zero
      assign regs[k] = '0;
      assign byp_hit[k] = 1'b0;
    end
  end
  assign OutA = byp_hit[OutASel] ? I : regs[OutASel];
  assign OutB = byp_hit[OutBSel] ? I : regs[OutBSel];
endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: three parameterisations of reg_file_param checked against a behavioural model
module tb_reg_file_param;
  logic CLK = 0, RST = 0;
  logic [1:0] FunSel = 0;
  logic [4:0] rs = '1;
  logic [7:0] I = 0;
  logic [2:0] asel = 0, bsel = 0;
  logic [7:0] oa0, ob0, oa1, ob1, oa2, ob2;
  logic [3:0] z0, v0, z1, v1;
  logic [4:0] z2, v2;
  int vectors = 0, miscompares = 0;
  bit en = 0;
  int m [3][8];
  bit ov [3][8];
  int nr [3] = '{4, 4, 5};
  bit sat [3] = '{0, 1, 0};
  bit byp [3] = '{0, 1, 0};

  always #5 CLK = ~CLK;

  reg_file_param #(.WIDTH(8), .NUM_REGS(4), .SATURATE(0), .BYPASS(0)) d0 (
    .CLK(CLK), .RST(RST), .FunSel(FunSel), .RegSel(rs[3:0]), .I(I), .OutASel(asel[1:0]),
    .OutBSel(bsel[1:0]), .OutA(oa0), .OutB(ob0), .ZeroFlag(z0), .OvfFlag(v0));
  reg_file_param #(.WIDTH(8), .NUM_REGS(4), .SATURATE(1), .BYPASS(1)) d1 (
    .CLK(CLK), .RST(RST), .FunSel(FunSel), .RegSel(rs[3:0]), .I(I), .OutASel(asel[1:0]),
    .OutBSel(bsel[1:0]), .OutA(oa1), .OutB(ob1), .ZeroFlag(z1), .OvfFlag(v1));
  reg_file_param #(.WIDTH(8), .NUM_REGS(5), .SATURATE(0), .BYPASS(0)) d2 (
    .CLK(CLK), .RST(RST), .FunSel(FunSel), .RegSel(rs), .I(I), .OutASel(asel),
    .OutBSel(bsel), .OutA(oa2), .OutB(ob2), .ZeroFlag(z2), .OvfFlag(v2));

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int erd(input int d, input int idx);
    if (idx >= nr[d]) return 0;
    if (byp[d] && !RST && !rs[idx] && FunSel == 2) return int'(I);
    return m[d][idx];
  endfunction

  function automatic int ezero(input int d);
    int r = 0;
    for (int k = 0; k < nr[d]; k++) if (m[d][k] == 0) r |= 1 << k;
    return r;
  endfunction

  function automatic int eovf(input int d);
    int r = 0;
    for (int k = 0; k < nr[d]; k++) if (ov[d][k]) r |= 1 << k;
    return r;
  endfunction

  always @(posedge CLK) begin
    if (RST) en = 1;
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < nr[d]; k++)
        if (RST) begin
          m[d][k] = 0;
          ov[d][k] = 0;
        end else if (!rs[k]) begin
          case (FunSel)
            2'd0: if (m[d][k] == 0) begin m[d][k] = sat[d] ? 0 : 255; ov[d][k] = 1; end
                  else m[d][k] = m[d][k] - 1;
            2'd1: if (m[d][k] == 255) begin m[d][k] = sat[d] ? 255 : 0; ov[d][k] = 1; end
                  else m[d][k] = m[d][k] + 1;
            2'd2: m[d][k] = int'(I);
            default: begin m[d][k] = 0; ov[d][k] = 0; end
          endcase
        end
  end

  always @(negedge CLK) if (en) begin
    chk("d0 OutA", oa0, erd(0, asel[1:0]));
    chk("d0 OutB", ob0, erd(0, bsel[1:0]));
    chk("d0 Zero", z0, ezero(0));
    chk("d0 Ovf", v0, eovf(0));
    chk("d1 OutA", oa1, erd(1, asel[1:0]));
    chk("d1 OutB", ob1, erd(1, bsel[1:0]));
    chk("d1 Zero", z1, ezero(1));
    chk("d1 Ovf", v1, eovf(1));
    chk("d2 OutA", oa2, erd(2, asel));
    chk("d2 OutB", ob2, erd(2, bsel));
    chk("d2 Zero", z2, ezero(2));
    chk("d2 Ovf", v2, eovf(2));
  end

  task automatic drive(input logic r, input logic [4:0] s, input logic [1:0] f,
                       input logic [7:0] d, input logic [2:0] a, input logic [2:0] b);
    @(posedge CLK);
    #1;
    RST = r; rs = s; FunSel = f; I = d; asel = a; bsel = b;
  endtask

  task automatic look;
    @(negedge CLK);
    #1;
  endtask

  initial begin
    drive(1, 5'h1F, 0, 0, 0, 0);
    drive(0, 5'h1F, 0, 0, 0, 1);
    look;
    chk("rst OutA", oa0, 0);
    chk("rst OutB", ob0, 0);
    chk("rst Zero", z0, 4'hF);
    chk("rst Ovf", v0, 0);
    drive(0, 5'b11011, 2, 8'hFF, 2, 2);
    drive(0, 5'b11011, 1, 0, 2, 2);
    drive(0, 5'h1F, 0, 0, 2, 2);
    look;
    chk("wrap inc R2", oa0, 8'h00);
    chk("wrap inc ovf", v0[2], 1);
    chk("sat inc R2", oa1, 8'hFF);
    chk("sat inc ovf", v1[2], 1);
    drive(0, 5'b11110, 3, 0, 0, 0);
    drive(0, 5'b11110, 0, 0, 0, 0);
    drive(0, 5'h1F, 0, 0, 0, 0);
    look;
    chk("wrap dec R0", oa0, 8'hFF);
    chk("wrap dec ovf", v0[0], 1);
    chk("sat dec R0", oa1, 8'h00);
    chk("sat dec ovf", v1[0], 1);
    drive(0, 5'b11110, 0, 0, 0, 0);
    drive(0, 5'h1F, 0, 0, 0, 0);
    look;
    chk("dec2 R0", oa0, 8'hFE);
    chk("dec2 ovf sticky", v0[0], 1);
    drive(0, 5'b11110, 3, 0, 0, 0);
    drive(0, 5'h1F, 0, 0, 0, 0);
    look;
    chk("clr R0", oa0, 0);
    chk("clr ovf", v0[0], 0);
    chk("other ovf kept", v0[2], 1);
    drive(0, 5'b00000, 2, 8'h5A, 3, 3);
    drive(0, 5'h1F, 0, 0, 3, 3);
    look;
    chk("all load A", oa0, 8'h5A);
    chk("all load B", ob0, 8'h5A);
    drive(0, 5'b11101, 2, 8'h3C, 1, 1);
    look;
    chk("bypass on", oa1, 8'h3C);
    chk("bypass off", oa0, 8'h5A);
    drive(0, 5'h1F, 0, 0, 1, 1);
    look;
    chk("after load", oa0, 8'h3C);
    drive(0, 5'h1F, 0, 0, 7, 4);
    look;
    chk("out of range", oa2, 0);
    chk("R4 read", ob2, 8'h5A);
    drive(1, 5'b00000, 2, 8'h77, 0, 1);
    look;
    chk("no bypass in rst", oa1, 8'h5A);
    drive(0, 5'h1F, 0, 0, 0, 1);
    look;
    chk("rst wins Zero", z2, 5'h1F);
    chk("rst wins Ovf", v0, 0);
    chk("rst wins OutB", ob1, 0);
    for (int n = 0; n < 60; n++)
      drive(0, 5'(n * 13 + 5), n % 7 == 6 ? 2'd3 : n % 3 == 0 ? 2'd2 : 2'(n & 1),
            8'(n * 37 + 250), 3'(n), 3'(n * 3));
    drive(0, 5'h1F, 0, 0, 0, 0);
    look;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
